fft_stream_top: RTL and testbench
=================================

Name: fft_stream_top

Overview:
- Streaming-interface, in-place, iterative radix-2 decimation-in-time FFT/IFFT over N = 2^LAYER complex samples, with 32-bit signed real and imaginary parts.
- An upstream stream generator (data_gen) supplies one frame of N consecutive samples, tagged by a start pulse.
- The block loads the frame, runs LAYER butterfly stages with one shared butterfly, then streams N results in natural order, marked by out_first and out_last.
- Downstream logic consumes results, e.g. as a magnitude-squared monitor.

Parameters:
- LAYER, 3: log2 of transform size; N = 2^LAYER; legal range 1..10.
- TW_FRAC, 14: fractional bits of signed 16-bit twiddle factors.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse coincident with input sample 0.
- data_config  input  1  1 = forward FFT, 0 = inverse FFT.
- data_real  input  32  signed real part of input sample.
- data_img  input  32  signed imaginary part of input sample.
- out_real  output  32  signed real part of result.
- out_img  output  32  signed imaginary part of result.
- out_first  output  1  high with result bin 0.
- out_last  output  1  high with result bin N-1.

Behaviour:
- Reset: synchronous to clk, active-high. Every output is 0 during and after reset. The FSM returns to IDLE and any in-flight frame is discarded. Sample memory contents need not be cleared.
- FSM states: IDLE -> LOAD -> CALC -> OUT -> IDLE.
- IDLE: start=1 at edge t0 captures sample 0 and enters LOAD. data_config is latched at this edge for the whole frame.
- LOAD: samples k = 0..N-1 are taken on consecutive edges t0..t0+N-1, with no gaps. Each sample is written to memory address bitreverse(k, LAYER).
- CALC: LAYER stages, s = 1..LAYER, with span m = 2^s and N/2 butterflies per stage. Exactly one butterfly per cycle, so CALC takes LAYER*N/2 cycles.
  - Butterfly order: groups in ascending order; within a group, j = 0..m/2-1.
  - Operands are A at address g+j and B at address g+j+m/2.
  - Twiddle index is k = j*N/m.
- Twiddle ROM: N/2 entries, with Wr[k] = round(cos(2πk/N)*2^TW_FRAC) and Wi[k] = -round(sin(2πk/N)*2^TW_FRAC).
  - Inverse mode uses the conjugate (Wi negated).
  - The ROM is computed at elaboration by a constant function or a fixed table.
- Butterfly arithmetic:
  - Products are formed at 48-bit width.
  - tr = (Br*Wr - Bi*Wi) >>> TW_FRAC.
  - ti = (Br*Wi + Bi*Wr) >>> TW_FRAC (arithmetic shift, i.e. floor).
  - A' = A + t and B' = A - t, each truncated (wrapped) to 32 bits.
  - No per-stage scaling and no 1/N in inverse mode. Overflow wraps silently; avoiding it is the caller's responsibility.
- OUT: memory addresses 0..N-1 are presented on N consecutive cycles as out_real/out_img.
  - out_first is high for address 0 only; out_last is high for address N-1 only.
  - For N=1 case not supported (LAYER>=1).
  - Outside OUT, out_real, out_img, out_first and out_last are 0.
  - All outputs are registered.
- Latency: out_first is high in the cycle following edge t0 + N + LAYER*N/2 (21 edges after t0 for N=8). out_last follows N-1 cycles later. The block returns to IDLE on the edge after out_last's cycle.
- start while not IDLE is ignored, including during OUT; the next frame may start on any edge in IDLE.
- data_real/data_img are don't-care outside LOAD.

Test Plan:
- Impulse, forward, LAYER=3: x[0]=1000+0j, others 0 -> all 8 outputs 1000+0j. out_first at edge t0+21; out_last 7 cycles later.
- DC, forward: all x[k]=1000+0j -> X[0]=8000+0j, X[1..7]=0+0j.
- Shifted impulse: x[1]=16384+0j -> X[0]=16384, X[1]=11585-11585j, X[2]=0-16384j, X[3]=-11585-11585j, X[4]=-16384, X[5]=-11585+11585j, X[6]=0+16384j, X[7]=11585+11585j.
- Inverse, data_config=0: X[0]=8000, others 0 -> all outputs 8000+0j. X[1]=16384 -> out[2]=0+16384j (conjugate twiddles).
- Protocol: second start pulse during CALC and OUT -> ignored, with exactly one out_first/out_last pair. Back-to-back frame started the cycle after return to IDLE -> processed correctly.
- Reset mid-CALC: rst=1 for one edge -> all outputs 0, no out_first. A new frame afterwards produces correct results.

Source files
------------

// File: rtl/fft_stream_top.sv
// fft_stream_top: streaming in-place radix-2 DIT FFT/IFFT over 2^LAYER complex samples,
// sharing one single-cycle butterfly across all stages.
module fft_stream_top #(
   parameter int LAYER   = 3,
   parameter int TW_FRAC = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               data_config,
   input  logic signed [31:0] data_real,
   input  logic signed [31:0] data_img,
   output logic signed [31:0] out_real,
   output logic signed [31:0] out_img,
   output logic               out_first,
   output logic               out_last
);
   localparam int N  = 1 << LAYER;
   localparam int KW = (LAYER > 1) ? LAYER - 1 : 1;

   typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

   state_t             state;
   logic               cfg;
   logic [LAYER-1:0]   cnt, bfly, half_m, j, addr_a, addr_b;
   logic [3:0]         st;
   logic [KW-1:0]      tk;
   logic signed [31:0] mem_r [N];
   logic signed [31:0] mem_i [N];
   logic signed [15:0] rom_r [1 << KW];
   logic signed [15:0] rom_i [1 << KW];
   logic signed [15:0] w_r, w_i;
   logic signed [31:0] a_r, a_i, b_r, b_i, t_r, t_i;

   // Fixed-point Taylor series (2^-28 resolution) so the ROM folds to constants
   // without needing real-valued math at elaboration.
   function automatic int trig(input int k, input bit sine);
      longint th, th2, term, acc;
      th   = (longint'(843314857) * 2 * longint'(k)) / N;
      th2  = (th * th) >>> 28;
      term = sine ? th : (longint'(1) << 28);
      acc  = term;
      for (int n = 1; n < 24; n++) begin
         term = -((term * th2) >>> 28) / longint'(sine ? (2 * n) * (2 * n + 1) : (2 * n - 1) * (2 * n));
         acc  = acc + term;
      end
      return int'((acc + (longint'(1) << 13)) >>> 14);
   endfunction

   function automatic logic [LAYER-1:0] bitrev(input logic [LAYER-1:0] x);
      logic [LAYER-1:0] r;
      for (int i = 0; i < LAYER; i++) r[i] = x[LAYER-1-i];
      return r;
   endfunction

   for (genvar g = 0; g < (1 << KW); g++) begin : g_rom
      assign rom_r[g] = 16'(trig(g, 1'b0));
      assign rom_i[g] = 16'(-trig(g, 1'b1));
   end

   always_comb begin
      half_m = LAYER'(1) << st;
      j      = bfly & (half_m - 1'b1);
      addr_a = ((bfly >> st) << (st + 4'd1)) | j;
      addr_b = addr_a | half_m;
      tk     = KW'(j << (LAYER - 1 - st));
      w_r    = rom_r[tk];
      w_i    = cfg ? rom_i[tk] : -rom_i[tk];
      a_r    = mem_r[addr_a];
      a_i    = mem_i[addr_a];
      b_r    = mem_r[addr_b];
      b_i    = mem_i[addr_b];
      t_r    = 32'((48'(b_r) * 48'(w_r) - 48'(b_i) * 48'(w_i)) >>> TW_FRAC);
      t_i    = 32'((48'(b_r) * 48'(w_i) + 48'(b_i) * 48'(w_r)) >>> TW_FRAC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bfly      <= '0;
         st        <= '0;
         cfg       <= 1'b0;
         out_real  <= '0;
         out_img   <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         out_real  <= '0;
         out_img   <= '0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               mem_r[0] <= data_real;
               mem_i[0] <= data_img;
               cfg      <= data_config;
               cnt      <= LAYER'(1);
               state    <= LOAD;
            end
            LOAD: begin
               mem_r[bitrev(cnt)] <= data_real;
               mem_i[bitrev(cnt)] <= data_img;
               cnt                <= cnt + 1'b1;
               if (cnt == LAYER'(N - 1)) begin
                  bfly  <= '0;
                  st    <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               mem_r[addr_a] <= a_r + t_r;
               mem_i[addr_a] <= a_i + t_i;
               mem_r[addr_b] <= a_r - t_r;
               mem_i[addr_b] <= a_i - t_i;
               bfly          <= (bfly == LAYER'(N / 2 - 1)) ? '0 : bfly + 1'b1;
               if (bfly == LAYER'(N / 2 - 1)) begin
                  st <= st + 1'b1;
                  if (st == 4'(LAYER - 1)) begin
                     cnt   <= '0;
                     state <= OUT;
                  end
               end
            end
            OUT: begin
               out_real  <= mem_r[cnt];
               out_img   <= mem_i[cnt];
               out_first <= (cnt == '0);
               out_last  <= (cnt == LAYER'(N - 1));
               cnt       <= cnt + 1'b1;
               if (cnt == LAYER'(N - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_stream_top.sv
// tb_fft_stream_top: directed frames against an array-level FFT model plus literal bins.
module tb_fft_stream_top;
   localparam int LAYER = 3;
   localparam int N     = 1 << LAYER;
   localparam int LAT   = 20;
   localparam real PI   = 3.14159265358979323846;

   logic               clk = 1'b0, rst = 1'b1, start = 1'b0, data_config = 1'b1;
   logic signed [31:0] data_real = '0, data_img = '0;
   logic signed [31:0] out_real, out_img;
   logic               out_first, out_last;

   int     cyc = 0, errors = 0, checks = 0, win_start = -1;
   bit     chk_en = 1'b0;
   longint xr [N], xi [N];
   int     er [N], ei [N], cr [N], ci [N], lr [N], li [N];
   int     idx, x_r, x_i;
   bit     inw;

   fft_stream_top #(.LAYER(LAYER), .TW_FRAC(14)) dut (
      .clk(clk), .rst(rst), .start(start), .data_config(data_config),
      .data_real(data_real), .data_img(data_img),
      .out_real(out_real), .out_img(out_img),
      .out_first(out_first), .out_last(out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   function automatic longint wrap32(input longint v);
      return longint'(int'(v));
   endfunction

   function automatic longint rnd(input real v);
      return v >= 0.0 ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
   endfunction

   function automatic int brev(input int k);
      int r = 0;
      for (int b = 0; b < LAYER; b++) r |= ((k >> b) & 1) << (LAYER - 1 - b);
      return r;
   endfunction

   // Textbook iterative DIT FFT on plain arrays.
   task automatic model(input bit cfg);
      longint r [N], im [N];
      longint wr, wi, tr, ti, ar, ai, br, bi;
      int m, h, kk;
      for (int k = 0; k < N; k++) begin
         r[brev(k)]  = xr[k];
         im[brev(k)] = xi[k];
      end
      for (int s = 1; s <= LAYER; s++) begin
         m = 1 << s;
         h = m / 2;
         for (int g = 0; g < N; g += m)
            for (int q = 0; q < h; q++) begin
               kk = q * N / m;
               wr = rnd($cos(2.0 * PI * kk / N) * 16384.0);
               wi = -rnd($sin(2.0 * PI * kk / N) * 16384.0);
               if (!cfg) wi = -wi;
               ar = r[g+q];   ai = im[g+q];
               br = r[g+q+h]; bi = im[g+q+h];
               tr = (br * wr - bi * wi) >>> 14;
               ti = (br * wi + bi * wr) >>> 14;
               r[g+q]    = wrap32(ar + tr);
               im[g+q]   = wrap32(ai + ti);
               r[g+q+h]  = wrap32(ar - tr);
               im[g+q+h] = wrap32(ai - ti);
            end
      end
      for (int k = 0; k < N; k++) begin
         er[k] = int'(r[k]);
         ei[k] = int'(im[k]);
      end
   endtask

   // Every cycle: outputs equal the model inside the expected window, zero elsewhere.
   always @(negedge clk) if (chk_en) begin
      idx = cyc - win_start;
      inw = (win_start >= 0) && (idx >= 0) && (idx < N);
      x_r = 0;
      x_i = 0;
      if (inw) begin
         x_r = er[idx];
         x_i = ei[idx];
      end
      checks++;
      if (out_real !== x_r || out_img !== x_i || out_first !== (inw && idx == 0) ||
          out_last !== (inw && idx == N - 1)) begin
         errors++;
         $display("FAIL stream cyc=%0d: got re=%0d im=%0d first=%0b last=%0b, want re=%0d im=%0d first=%0b last=%0b",
                  cyc, out_real, out_img, out_first, out_last, x_r, x_i, inw && idx == 0, inw && idx == N - 1);
      end
   end

   task automatic clear_x();
      for (int k = 0; k < N; k++) begin
         xr[k] = 0;
         xi[k] = 0;
      end
   endtask

   // mode 0: plain frame, 1: extra start pulses in CALC and OUT, 2: reset mid-CALC
   task automatic run_frame(input bit cfg, input int mode);
      int t0;
      bit seen;
      @(negedge clk);
      model(cfg);
      t0          = cyc + 1;
      win_start   = t0 + LAT;
      start       = 1'b1;
      data_config = cfg;
      data_real   = 32'(xr[0]);
      data_img    = 32'(xi[0]);
      for (int k = 1; k < N; k++) begin
         @(negedge clk);
         start     = 1'b0;
         data_real = 32'(xr[k]);
         data_img  = 32'(xi[k]);
      end
      @(negedge clk);
      data_real   = 32'h1234_5678;
      data_img    = -32'sd7;
      data_config = ~cfg;
      seen = 1'b0;
      for (int w = 0; w < 40; w++) begin
         start = (mode == 1) && (cyc == t0 + 11);
         rst   = (mode == 2) && (cyc == t0 + 11);
         if (rst) win_start = -1;
         @(negedge clk);
         if (out_first) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      rst   = 1'b0;
      if (mode == 2) begin
         chk("rst_no_first", seen, 0);
         return;
      end
      chk("first_seen", seen, 1);
      if (!seen) return;
      chk("latency", cyc - t0, LAT);
      for (int k = 0; k < N; k++) begin
         cr[k] = out_real;
         ci[k] = out_img;
         start = (mode == 1) && (k == 2);
         if (k < N - 1) @(negedge clk);
      end
      start = 1'b0;
      chk("last_flag", out_last, 1);
   endtask

   task automatic cmp_lit(input string name);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("%s_re[%0d]", name, k), cr[k], lr[k]);
         chk($sformatf("%s_im[%0d]", name, k), ci[k], li[k]);
      end
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_real", out_real, 0);
      chk("rst_img", out_img, 0);
      chk("rst_first", out_first, 0);
      chk("rst_last", out_last, 0);
      rst = 1'b0;

      clear_x(); xr[0] = 1000;
      run_frame(1'b1, 0);
      lr = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
      li = '{0, 0, 0, 0, 0, 0, 0, 0};
      cmp_lit("impulse");

      clear_x(); for (int k = 0; k < N; k++) xr[k] = 1000;
      run_frame(1'b1, 0);
      lr = '{8000, 0, 0, 0, 0, 0, 0, 0};
      cmp_lit("dc");

      clear_x(); xr[1] = 16384;
      run_frame(1'b1, 0);
      lr = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
      li = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};
      chk("model_x1_re", er[1], 11585);
      chk("model_x3_im", ei[3], -11585);
      cmp_lit("shift");

      clear_x(); xr[0] = 8000;
      run_frame(1'b0, 0);
      lr = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
      li = '{0, 0, 0, 0, 0, 0, 0, 0};
      cmp_lit("inv_dc");

      clear_x(); xr[1] = 16384;
      run_frame(1'b0, 1);
      chk("model_inv2_im", ei[2], 16384);
      chk("inv_out2_re", cr[2], 0);
      chk("inv_out2_im", ci[2], 16384);

      xr = '{100, -250, 3000, -47, 512, 7, -9000, 1234};
      xi = '{-3, 77, -600, 2500, 0, -1, 42, -8000};
      run_frame(1'b1, 0);
      chk("mix_x0_re", cr[0], -4444);
      chk("mix_x0_im", ci[0], -5985);
      chk("mix_x4_re", cr[4], -6332);
      chk("mix_x4_im", ci[4], 4863);

      clear_x(); xr[0] = 1000;
      run_frame(1'b1, 2);

      clear_x(); xr[1] = 16384;
      run_frame(1'b1, 0);
      lr = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
      li = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};
      cmp_lit("recover");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
